// File: rtl/fc_cmd_pkg.sv
// Shared fast-command definitions: one-hot fcd bit indices, default limits and widths.
// Used by the decoder, the dispatcher and its testbench.
package fc_cmd_pkg;

  localparam int FCD_W          = 10;
  localparam int BCID_W         = 12;
  localparam int EVT_W          = 16;
  localparam int ERR_W          = 16;
  localparam int BC_MAX_DEF     = 3563;
  localparam int QINJ_DLY_W_DEF = 5;

  localparam int FC_IDLE        = 0;
  localparam int FC_LINK_RESET  = 1;
  localparam int FC_BCR         = 2;
  localparam int FC_SYNC_TRIG   = 3;
  localparam int FC_L1A_CR      = 4;
  localparam int FC_CHARGE_INJ  = 5;
  localparam int FC_L1A         = 6;
  localparam int FC_L1A_BCR     = 7;
  localparam int FC_WS_START    = 8;
  localparam int FC_WS_STOP     = 9;

  typedef enum logic {
    QINJ_IDLE  = 1'b0,
    QINJ_COUNT = 1'b1
  } qinj_state_e;

  // True when exactly one bit is set; zero and multi-hot words are both rejected.
  function automatic logic is_one_hot(input logic [FCD_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/fc_bcid_counter.sv
// Bunch-crossing counter: free-running, wraps MAX -> 0, synchronous load of LOAD_VAL.
module fc_bcid_counter
  import fc_cmd_pkg::*;
#(
  parameter int unsigned MAX      = BC_MAX_DEF,
  parameter int unsigned LOAD_VAL = 0
) (
  input  logic              clk40,
  input  logic              reset,
  input  logic              load,
  output logic [BCID_W-1:0] bcid
);

  localparam logic [BCID_W-1:0] MAX_V  = BCID_W'(MAX);
  localparam logic [BCID_W-1:0] LOAD_V = BCID_W'(LOAD_VAL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset)             bcid <= '0;
    else if (load)          bcid <= LOAD_V;
    else if (bcid == MAX_V) bcid <= '0;
    else                    bcid <= bcid + 1'b1;
  end

endmodule

// File: rtl/fast_command_dispatcher.sv
// Turns decoded one-hot fast commands into registered timing actions (BCID, L1A, link reset,
// sync, delayed charge injection, waveform-sampler window) and counts rejected words.
module fast_command_dispatcher
  import fc_cmd_pkg::*;
#(
  parameter int unsigned BC_MAX     = BC_MAX_DEF,
  parameter int unsigned BCR_OFFSET = 0,
  parameter int unsigned QINJ_DLY_W = QINJ_DLY_W_DEF
) (
  input  logic                  clk40,
  input  logic                  reset,
  input  logic [FCD_W-1:0]      fcd,
  input  logic                  aligned,
  input  logic                  invalidCmd,
  input  logic [QINJ_DLY_W-1:0] qinjDelay,
  output logic [BCID_W-1:0]     bcid,
  output logic                  l1a,
  output logic [EVT_W-1:0]      eventId,
  output logic                  linkReset,
  output logic                  syncTrig,
  output logic                  qinj,
  output logic                  qinjBusy,
  output logic                  wsActive,
  output logic [ERR_W-1:0]      errCnt
);

  logic                  accepted;
  logic                  rejected;
  logic [FCD_W-1:0]      cmd;
  logic                  qinj_drop;
  logic                  err_inc;
  logic                  bcid_load;
  logic [EVT_W-1:0]      l1a_cnt;
  logic [QINJ_DLY_W-1:0] qinj_cnt;
  qinj_state_e           qinj_state;

  // cmd is the command word gated by acceptance, so downstream logic never sees rejected bits.
  assign accepted  = aligned & ~invalidCmd & is_one_hot(fcd);
  assign rejected  = aligned & ~accepted;
  assign cmd       = accepted ? fcd : '0;
  assign qinj_drop = cmd[FC_CHARGE_INJ] & (qinj_state == QINJ_COUNT);
  assign err_inc   = rejected | qinj_drop;
  assign bcid_load = cmd[FC_BCR] | cmd[FC_L1A_BCR];

  fc_bcid_counter #(
    .MAX      (BC_MAX),
    .LOAD_VAL (BCR_OFFSET)
  ) u_bcid (
    .clk40 (clk40),
    .reset (reset),
    .load  (bcid_load),
    .bcid  (bcid)
  );

  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      l1a        <= 1'b0;
      eventId    <= '0;
      l1a_cnt    <= '0;
      linkReset  <= 1'b0;
      syncTrig   <= 1'b0;
      qinj       <= 1'b0;
      qinjBusy   <= 1'b0;
      qinj_cnt   <= '0;
      qinj_state <= QINJ_IDLE;
      wsActive   <= 1'b0;
      errCnt     <= '0;
    end else begin
      l1a       <= cmd[FC_L1A] | cmd[FC_L1A_CR] | cmd[FC_L1A_BCR];
      linkReset <= cmd[FC_LINK_RESET];
      syncTrig  <= cmd[FC_SYNC_TRIG];

      if (cmd[FC_L1A_CR]) begin
        eventId <= '0;
        l1a_cnt <= EVT_W'(1);
      end else if (cmd[FC_L1A] | cmd[FC_L1A_BCR]) begin
        eventId <= l1a_cnt;
        l1a_cnt <= l1a_cnt + 1'b1;
      end

      if (!aligned)              wsActive <= 1'b0;
      else if (cmd[FC_WS_START]) wsActive <= 1'b1;
      else if (cmd[FC_WS_STOP])  wsActive <= 1'b0;

      if (err_inc && (errCnt != '1)) errCnt <= errCnt + 1'b1;

      // Countdown fires on the edge after cnt reaches 1, giving qinjDelay+1 cycles total.
      qinj <= 1'b0;
      case (qinj_state)
        QINJ_IDLE: begin
          if (cmd[FC_CHARGE_INJ]) begin
            if (qinjDelay == '0) begin
              qinj <= 1'b1;
            end else begin
              qinj_cnt   <= qinjDelay;
              qinjBusy   <= 1'b1;
              qinj_state <= QINJ_COUNT;
            end
          end
        end
        QINJ_COUNT: begin
          if (!aligned) begin
            qinj_cnt   <= '0;
            qinjBusy   <= 1'b0;
            qinj_state <= QINJ_IDLE;
          end else if (qinj_cnt == QINJ_DLY_W'(1)) begin
            qinj       <= 1'b1;
            qinjBusy   <= 1'b0;
            qinj_state <= QINJ_IDLE;
          end else begin
            qinj_cnt <= qinj_cnt - 1'b1;
          end
        end
        default: qinj_state <= QINJ_IDLE;
      endcase
    end
  end

endmodule
